// File: rtl/ssp_pkg.sv
// Shared constants for the issue scoreboard: default widths and the
// result latencies of the instruction classes that feed in_lat.
package ssp_pkg;

  localparam int RADDR_W_DEF = 5;
  localparam int LAT_W_DEF   = 3;

  typedef enum logic [1:0] {
    OP_ALU    = 2'd0,
    OP_MUL    = 2'd1,
    OP_LOAD   = 2'd2,
    OP_BRANCH = 2'd3
  } op_class_e;

  // Cycles from issue to write-back for each instruction class.
  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;
  localparam int LAT_MUL  = 4;

endpackage

// File: rtl/sb_reg_counter.sv
// Pending-write down-counter for one architectural register.
// A load wins over the decrement, the count saturates at zero, and
// busy is registered alongside the count so it tracks cnt != 0.
module sb_reg_counter #(
  parameter int LAT_W = 3
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] cnt,
  output logic             busy
);

  logic [LAT_W-1:0] cnt_reg;
  logic [LAT_W-1:0] cnt_next;
  logic             busy_reg;

  // Next count: flush clears, load beats decrement, zero holds.
  always_comb begin
    cnt_next = cnt_reg;
    if (flush) begin
      cnt_next = '0;
    end else if (load) begin
      cnt_next = load_val;
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - LAT_W'(1);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk1) begin
    if (!reset) begin
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      busy_reg <= (cnt_next != '0);
    end
  end

  assign cnt  = cnt_reg;
  assign busy = busy_reg;

endmodule

// File: rtl/issue_scoreboard.sv
// In-order multi-issue register scoreboard. Each register tracks the
// cycles left until its pending result is written back; an instruction
// issues only when its sources, destination and earlier bundle slots
// allow it, and every slot behind a stalled slot is held back too.
module issue_scoreboard
  import ssp_pkg::*;
#(
  parameter int ISSUE_W  = 2,
  parameter int NREG     = 1 << RADDR_W_DEF,
  parameter int LAT_W    = LAT_W_DEF,
  parameter int BYPASS   = 1,
  localparam int RADDR_W = $clog2(NREG)
) (
  input  logic                       clk1,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [ISSUE_W-1:0]         in_valid,
  input  logic [ISSUE_W*RADDR_W-1:0] in_rs1,
  input  logic [ISSUE_W*RADDR_W-1:0] in_rs2,
  input  logic [ISSUE_W*RADDR_W-1:0] in_rd,
  input  logic [ISSUE_W-1:0]         in_wen,
  input  logic [ISSUE_W*LAT_W-1:0]   in_lat,
  output logic [ISSUE_W-1:0]         issue_ok,
  output logic                       stall,
  output logic [NREG-1:0]            busy_vec
);

  // A source may read a register whose count is at most this value.
  localparam logic [LAT_W-1:0] BYP = LAT_W'(BYPASS);

  logic [RADDR_W-1:0] rs1_s     [ISSUE_W];
  logic [RADDR_W-1:0] rs2_s     [ISSUE_W];
  logic [RADDR_W-1:0] rd_s      [ISSUE_W];
  logic [LAT_W-1:0]   eff_lat_s [ISSUE_W];

  logic [LAT_W-1:0]   cnt       [NREG];
  logic [NREG-1:1]    load_en;
  logic [LAT_W-1:0]   load_val  [1:NREG-1];

  // Split the flat slot buses; a zero latency still occupies one cycle.
  for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_slot
    assign rs1_s[gi] = in_rs1[gi*RADDR_W +: RADDR_W];
    assign rs2_s[gi] = in_rs2[gi*RADDR_W +: RADDR_W];
    assign rd_s[gi]  = in_rd[gi*RADDR_W +: RADDR_W];
    assign eff_lat_s[gi] = (in_lat[gi*LAT_W +: LAT_W] == '0) ?
                           LAT_W'(1) : in_lat[gi*LAT_W +: LAT_W];
  end

  // Hazard detection and in-order issue chain across the bundle.
  always_comb begin
    logic chain_ok;
    logic haz;
    chain_ok = 1'b1;
    haz      = 1'b0;
    issue_ok = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      haz = 1'b0;
      if (rs1_s[k] != '0 && cnt[rs1_s[k]] > BYP) haz = 1'b1;
      if (rs2_s[k] != '0 && cnt[rs2_s[k]] > BYP) haz = 1'b1;
      if (in_wen[k] && rd_s[k] != '0 && cnt[rd_s[k]] > eff_lat_s[k]) haz = 1'b1;
      for (int j = 0; j < k; j++) begin
        if (in_valid[j] && in_wen[j] && rd_s[j] != '0 &&
            (rs1_s[k] == rd_s[j] || rs2_s[k] == rd_s[j] || rd_s[k] == rd_s[j])) begin
          haz = 1'b1;
        end
      end
      issue_ok[k] = in_valid[k] & ~haz & chain_ok & ~flush;
      chain_ok    = chain_ok & (issue_ok[k] | ~in_valid[k]);
    end
  end

  assign stall = |(in_valid & ~issue_ok);

  // Route each issuing writer's latency to its destination counter.
  always_comb begin
    load_en = '0;
    for (int r = 1; r < NREG; r++) begin
      load_val[r] = '0;
    end
    for (int k = 0; k < ISSUE_W; k++) begin
      for (int r = 1; r < NREG; r++) begin
        if (issue_ok[k] && in_wen[k] && rd_s[k] == RADDR_W'(r)) begin
          load_en[r]  = 1'b1;
          load_val[r] = eff_lat_s[k];
        end
      end
    end
  end

  // Register 0 is hard-wired idle.
  assign cnt[0]      = '0;
  assign busy_vec[0] = 1'b0;

  for (genvar gi = 1; gi < NREG; gi++) begin : g_cnt
    sb_reg_counter #(
      .LAT_W (LAT_W)
    ) u_cnt (
      .clk1     (clk1),
      .reset    (reset),
      .flush    (flush),
      .load     (load_en[gi]),
      .load_val (load_val[gi]),
      .cnt      (cnt[gi]),
      .busy     (busy_vec[gi])
    );
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: a vector table on a 2-wide
// BYPASS=1 instance, plus hand sequences on a BYPASS=0 twin and a
// 4-wide instance.
module tb_issue_scoreboard;
  import ssp_pkg::*;

  logic        clk1;
  logic        reset;
  logic        flush;
  logic [1:0]  in_valid;
  logic [9:0]  in_rs1;
  logic [9:0]  in_rs2;
  logic [9:0]  in_rd;
  logic [1:0]  in_wen;
  logic [5:0]  in_lat;
  logic [1:0]  a_ok;
  logic        a_stall;
  logic [31:0] a_busy;
  logic [1:0]  b_ok;
  logic        b_stall;
  logic [31:0] b_busy;

  logic [3:0]  c_valid;
  logic [19:0] c_rs1;
  logic [19:0] c_rs2;
  logic [19:0] c_rd;
  logic [3:0]  c_wen;
  logic [11:0] c_lat;
  logic [3:0]  c_ok;
  logic        c_stall;
  logic [31:0] c_busy;

  int checks = 0;
  int errors = 0;

  issue_scoreboard #(.ISSUE_W(2), .NREG(32), .LAT_W(3), .BYPASS(1)) dut_a (
    .clk1(clk1), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wen(in_wen),
    .in_lat(in_lat), .issue_ok(a_ok), .stall(a_stall), .busy_vec(a_busy));

  issue_scoreboard #(.ISSUE_W(2), .NREG(32), .LAT_W(3), .BYPASS(0)) dut_b (
    .clk1(clk1), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wen(in_wen),
    .in_lat(in_lat), .issue_ok(b_ok), .stall(b_stall), .busy_vec(b_busy));

  issue_scoreboard #(.ISSUE_W(4), .NREG(32), .LAT_W(3), .BYPASS(1)) dut_c (
    .clk1(clk1), .reset(reset), .flush(1'b0), .in_valid(c_valid),
    .in_rs1(c_rs1), .in_rs2(c_rs2), .in_rd(c_rd), .in_wen(c_wen),
    .in_lat(c_lat), .issue_ok(c_ok), .stall(c_stall), .busy_vec(c_busy));

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  typedef struct {
    bit         fl;
    bit [1:0]   v;
    bit [1:0]   w;
    int         rd0, a0, b0, l0;
    int         rd1, a1, b1, l1;
    bit [1:0]   eok;
    bit         est;
    bit [31:0]  ebusy;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(bit fl, bit [1:0] v, bit [1:0] w,
                              int rd0, int a0, int b0, int l0,
                              int rd1, int a1, int b1, int l1,
                              bit [1:0] eok, bit est, bit [31:0] ebusy);
    vec_t t;
    t.fl = fl; t.v = v; t.w = w;
    t.rd0 = rd0; t.a0 = a0; t.b0 = b0; t.l0 = l0;
    t.rd1 = rd1; t.a1 = a1; t.b1 = b1; t.l1 = l1;
    t.eok = eok; t.est = est; t.ebusy = ebusy;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive2(input bit fl, input bit [1:0] v, input bit [1:0] w,
                        input int rd0, input int a0, input int b0, input int l0,
                        input int rd1, input int a1, input int b1, input int l1);
    flush    = fl;
    in_valid = v;
    in_wen   = w;
    in_rd    = {5'(rd1), 5'(rd0)};
    in_rs1   = {5'(a1), 5'(a0)};
    in_rs2   = {5'(b1), 5'(b0)};
    in_lat   = {3'(l1), 3'(l0)};
  endtask

  task automatic setc(input int s, input bit v, input bit w, input int rd,
                      input int a, input int b, input int l);
    c_valid[s]         = v;
    c_wen[s]           = w;
    c_rd[s*5 +: 5]     = 5'(rd);
    c_rs1[s*5 +: 5]    = 5'(a);
    c_rs2[s*5 +: 5]    = 5'(b);
    c_lat[s*3 +: 3]    = 3'(l);
  endtask

  task automatic idle_c();
    for (int s = 0; s < 4; s++) setc(s, 0, 0, 0, 0, 0, 0);
  endtask

  // Commit the current inputs on the next rising edge, then step off it.
  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive2(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_c();
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // Vector table: consecutive cycles on dut_a, state carries over.
    tbl[0]  = mk(0, 2'b00, 2'b00,  0, 0, 0, 0,   0, 0, 0, 0,  2'b00, 0, 32'h0);
    tbl[1]  = mk(0, 2'b11, 2'b11, 14, 1, 2, 1,  15, 2, 14, 1, 2'b01, 1, 32'h0);
    tbl[2]  = mk(0, 2'b01, 2'b01, 15, 2, 14, 1,  0, 0, 0, 0,  2'b01, 0, 32'h4000);
    tbl[3]  = mk(0, 2'b01, 2'b01,  3, 0, 0, 4,   0, 0, 0, 0,  2'b01, 0, 32'h8000);
    tbl[4]  = mk(0, 2'b11, 2'b11, 16, 3, 0, 1,  17, 1, 2, 1,  2'b00, 1, 32'h8);
    tbl[5]  = mk(1, 2'b01, 2'b00,  0, 3, 0, 0,   0, 0, 0, 0,  2'b00, 1, 32'h8);
    tbl[6]  = mk(0, 2'b01, 2'b00,  0, 3, 0, 0,   0, 0, 0, 0,  2'b01, 0, 32'h0);
    tbl[7]  = mk(0, 2'b01, 2'b01,  0, 0, 0, 5,   0, 0, 0, 0,  2'b01, 0, 32'h0);
    tbl[8]  = mk(0, 2'b11, 2'b00,  0, 0, 0, 0,   0, 0, 0, 0,  2'b11, 0, 32'h0);
    tbl[9]  = mk(0, 2'b01, 2'b01,  9, 0, 0, 5,   0, 0, 0, 0,  2'b01, 0, 32'h0);
    tbl[10] = mk(0, 2'b01, 2'b01,  9, 0, 0, 2,   0, 0, 0, 0,  2'b00, 1, 32'h200);
    tbl[11] = mk(0, 2'b01, 2'b01,  9, 0, 0, 4,   0, 0, 0, 0,  2'b01, 0, 32'h200);
    tbl[12] = mk(0, 2'b01, 2'b01,  9, 0, 0, 0,   0, 0, 0, 0,  2'b00, 1, 32'h200);
    tbl[13] = mk(0, 2'b00, 2'b00,  0, 0, 0, 0,   0, 0, 0, 0,  2'b00, 0, 32'h200);
    tbl[14] = mk(0, 2'b00, 2'b00,  0, 0, 0, 0,   0, 0, 0, 0,  2'b00, 0, 32'h200);
    tbl[15] = mk(0, 2'b11, 2'b01, 20, 9, 0, 3,   0, 20, 0, 0, 2'b01, 1, 32'h200);
    tbl[16] = mk(0, 2'b10, 2'b11,  5, 0, 0, 1,  21, 5, 0, 2,  2'b10, 0, 32'h0010_0000);
    tbl[17] = mk(0, 2'b00, 2'b00,  0, 0, 0, 0,   0, 0, 0, 0,  2'b00, 0, 32'h0030_0000);
    tbl[18] = mk(0, 2'b00, 2'b00,  0, 0, 0, 0,   0, 0, 0, 0,  2'b00, 0, 32'h0030_0000);
    tbl[19] = mk(0, 2'b00, 2'b00,  0, 0, 0, 0,   0, 0, 0, 0,  2'b00, 0, 32'h0);
    tbl[20] = mk(0, 2'b00, 2'b00,  0, 0, 0, 0,   0, 0, 0, 0,  2'b00, 0, 32'h0);
    tbl[21] = mk(0, 2'b11, 2'b11, 10, 0, 0, 1,  10, 0, 0, 1,  2'b01, 1, 32'h0);
    tbl[22] = mk(0, 2'b00, 2'b00,  0, 0, 0, 0,   0, 0, 0, 0,  2'b00, 0, 32'h400);

    do_reset();

    for (int i = 0; i < 23; i++) begin
      drive2(tbl[i].fl, tbl[i].v, tbl[i].w,
             tbl[i].rd0, tbl[i].a0, tbl[i].b0, tbl[i].l0,
             tbl[i].rd1, tbl[i].a1, tbl[i].b1, tbl[i].l1);
      @(negedge clk1);
      $display("vec %0d: ok=%b stall=%b busy=%h", i, a_ok, a_stall, a_busy);
      chk($sformatf("vec%0d_issue_ok", i), 32'(a_ok), 32'(tbl[i].eok));
      chk($sformatf("vec%0d_stall", i), 32'(a_stall), 32'(tbl[i].est));
      chk($sformatf("vec%0d_busy_vec", i), a_busy, tbl[i].ebusy);
      tick();
    end

    // Latency-4 writer to R5 followed by a reader each cycle.
    do_reset();
    drive2(0, 2'b01, 2'b01, 5, 0, 0, 4, 0, 0, 0, 0);
    @(negedge clk1);
    $display("raw writer: b_ok=%b", b_ok);
    chk("raw_writer_issue", 32'(b_ok), 32'h1);
    tick();
    for (int c = 0; c < 5; c++) begin
      drive2(0, 2'b01, 2'b00, 0, 5, 0, 0, 0, 0, 0, 0);
      @(negedge clk1);
      $display("raw reader cycle %0d: b_ok=%b b_busy5=%b a_ok=%b", c, b_ok, b_busy[5], a_ok);
      chk($sformatf("raw_nobyp_c%0d_issue", c), 32'(b_ok), (c == 4) ? 32'h1 : 32'h0);
      chk($sformatf("raw_nobyp_c%0d_busy5", c), 32'(b_busy[5]), (c < 4) ? 32'h1 : 32'h0);
      chk($sformatf("raw_byp_c%0d_issue", c), 32'(a_ok), (c >= 3) ? 32'h1 : 32'h0);
      tick();
    end
    drive2(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk1);
    chk("raw_after_busy", b_busy, 32'h0);
    tick();

    // Six busy registers then a reset pulse mid-operation.
    drive2(0, 2'b11, 2'b11, 1, 0, 0, 7, 2, 0, 0, 7);
    tick();
    drive2(0, 2'b11, 2'b11, 3, 0, 0, 7, 4, 0, 0, 7);
    tick();
    drive2(0, 2'b11, 2'b11, 5, 0, 0, 7, 6, 0, 0, 7);
    tick();
    drive2(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk1);
    $display("six busy: busy=%h", a_busy);
    chk("rst_six_busy", a_busy, 32'h7E);
    reset = 1'b0;
    drive2(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    drive2(0, 2'b01, 2'b00, 0, 3, 4, 0, 0, 0, 0, 0);
    @(negedge clk1);
    $display("after reset: busy=%h ok=%b stall=%b", a_busy, a_ok, a_stall);
    chk("rst_busy_clear", a_busy, 32'h0);
    chk("rst_reader_issue", 32'(a_ok), 32'h1);
    chk("rst_no_stall", 32'(a_stall), 32'h0);
    tick();

    // Four-wide bundle: dependent pair in slots 0-1, independents behind.
    do_reset();
    setc(0, 1, 1, 14, 1, 2, LAT_ALU);
    setc(1, 1, 1, 15, 2, 14, LAT_ALU);
    setc(2, 1, 1, 20, 3, 4, LAT_ALU);
    setc(3, 1, 1, 21, 5, 6, LAT_ALU);
    @(negedge clk1);
    $display("wide bundle: ok=%b stall=%b", c_ok, c_stall);
    chk("wide_issue_ok", 32'(c_ok), 32'h1);
    chk("wide_stall", 32'(c_stall), 32'h1);
    tick();
    idle_c();
    setc(0, 1, 1, 15, 2, 14, LAT_ALU);
    @(negedge clk1);
    $display("wide replay: ok=%b stall=%b busy=%h", c_ok, c_stall, c_busy);
    chk("wide_replay_issue_ok", 32'(c_ok), 32'h1);
    chk("wide_replay_stall", 32'(c_stall), 32'h0);
    chk("wide_replay_busy", c_busy, 32'h4000);
    tick();
    idle_c();
    setc(0, 1, 1, 8, 0, 0, LAT_LOAD);
    setc(2, 1, 1, 22, 1, 2, LAT_ALU);
    setc(3, 1, 0, 0, 8, 0, 0);
    @(negedge clk1);
    $display("wide gap: ok=%b stall=%b", c_ok, c_stall);
    chk("wide_gap_issue_ok", 32'(c_ok), 32'h5);
    chk("wide_gap_stall", 32'(c_stall), 32'h1);
    tick();
    idle_c();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 Parameter ISSUE_W, default 2: instructions presented per cycle, from 1 to 4.
REQ-002 Parameter NREG, default 32: architectural registers; RADDR_W = clog2(NREG).
REQ-003 Parameter LAT_W, default 3: width of the per-instruction result-latency field.
REQ-004 Parameter BYPASS, default 1: 1 lets a source whose counter equals 1 issue (forwarded result); 0 requires counter 0.
REQ-005 clk1  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 flush  in  1  discard all pending-write tracking (branch/jump redirect).
REQ-008 in_valid  in  ISSUE_W  slot k holds an instruction.
REQ-009 in_rs1, in_rs2  in  ISSUE_W*RADDR_W  source register per slot; slot k occupies bits [k*RADDR_W +: RADDR_W].
REQ-010 in_rd  in  ISSUE_W*RADDR_W  destination register per slot.
REQ-011 in_wen  in  ISSUE_W  slot k writes in_rd.
REQ-012 in_lat  in  ISSUE_W*LAT_W  cycles until slot k's result is written back.
REQ-013 issue_ok  out  ISSUE_W  slot k issues this cycle; combinational.
REQ-014 stall  out  1  a valid slot did not issue; combinational.
REQ-015 busy_vec  out  NREG  bit r set when counter r is non-zero; registered.

Function
REQ-016 Each register r SHALL have a down-counter cnt[r] of LAT_W bits.
REQ-017 A source hazard SHALL exist when a source is non-zero and cnt[src] > BYPASS.
REQ-018 A WAW hazard SHALL exist when in_wen=1, rd≠0 and cnt[rd] > eff_lat, where eff_lat = max(in_lat, 1).
REQ-019 An intra-bundle hazard SHALL exist for slot k when its rs1, rs2 or rd equals the non-zero rd of any valid slot j<k with in_wen[j]=1.
REQ-020 Issue SHALL be in order: issue_ok[k] = in_valid[k] & no hazard & (k==0 | issue_ok[k-1] | !in_valid[k-1]).
REQ-021 A slot SHALL never issue after an earlier valid slot has stalled in the same cycle.
REQ-022 stall SHALL equal OR over k of (in_valid[k] & !issue_ok[k]).
REQ-023 Each cycle, cnt[rd] SHALL load eff_lat for an issuing writer; otherwise non-zero counters SHALL decrement by 1.
REQ-024 Register 0 SHALL never become busy; cnt[0] is held at 0.
REQ-025 A load and a decrement on the same counter in the same cycle SHALL resolve to the load.
REQ-026 Counters SHALL saturate at 0 and never wrap.
REQ-027 When flush=1, issue_ok SHALL be forced to 0 and all counters SHALL be 0 on the next edge.
REQ-028 Scoreboard changes SHALL become visible to issue_ok one cycle after the issuing edge.

Reset
REQ-029 While reset=0 at an edge, all counters and busy_vec SHALL clear to 0 next cycle; issue_ok and stall follow combinationally from the cleared state.
REQ-030 Reset mid-operation SHALL drop all pending writes without any residual stall; reset overrides flush.

Structure
REQ-031 RADDR_W, LAT_W defaults and the opcode/latency constants SHALL live in shared package ssp_pkg.
REQ-032 The per-register counter SHALL be sub-module sb_reg_counter, instantiated NREG-1 times through a generate loop.

Verification
REQ-033 Slot0 ADD R14←R1+R2 and slot1 ADD R15←R2+R14, both lat 1, BYPASS=1 -> issue_ok=01 and stall=1; slot1 alone re-presented next cycle -> issue_ok=01 (slot 0 bit), stall=0.
REQ-034 Writer to R5 with lat 4, then a reader of R5 each cycle, BYPASS=0 -> stalled 4 cycles, issues in the 5th; busy_vec[5] high for exactly 4 cycles.
REQ-035 Slot0 stalled on busy R3, slot1 independent -> issue_ok=00, proving in-order issue.
REQ-036 R7 busy with count 3, flush=1 -> issue_ok=00 that cycle; next cycle busy_vec=0 and a reader of R7 issues.
REQ-037 Writer to R0 with lat 5 -> busy_vec[0] stays 0 and a following reader of R0 issues immediately.
REQ-038 reset=0 with 6 busy registers -> busy_vec=0 the next cycle; ISSUE_W=4 rerun of REQ-033 with slots 2-3 independent -> issue_ok=0001.
